// File: rtl/sensor_seq.sv
// rtl/sensor_seq.sv - line-sensor readout sequencer: SENSOR_CLK/ST generation and EOC/EOS capture
//
// Purpose: generates the sensor drive clock and ST start pulse from FPGA_CLK
// using divider/period/high-time settings that are shadowed when a run starts.
// It synchronises EOC/EOS, emits per-pixel strobes with indices and per-line
// length capture, and flags pixel-counter saturation. Everything is clocked on
// FPGA_CLK; SENSOR_CLK is a registered data output only.
//
// Optional feature macro: SENSOR_SEQ_LEN_CHECK_EN (line-length comparator for LEN_ERR).
//
// Ports:
//   FPGA_CLK   in   system clock
//   FPGA_RST   in   asynchronous active-low reset
//   EN         in   run request (level)
//   DIV        in   SENSOR_CLK half-period minus 1
//   ST_PERIOD  in   ST period in sensor clocks
//   ST_HIGH    in   ST high time in sensor clocks
//   EOC, EOS   in   asynchronous sensor end-of-conversion / end-of-scan
//   SENSOR_CLK out  sensor drive clock
//   ST         out  sensor start pulse
//   BUSY       out  sequencer not idle
//   PIX_STB    out  one-cycle pixel strobe, PIX_IDX valid with it
//   LINE_DONE  out  one-cycle end-of-line strobe, LINE_LEN held
//   OVF        out  sticky pixel counter saturation
//   LEN_ERR    out  one-cycle line length mismatch
`timescale 1ns/1ps
module sensor_seq #(
  parameter int DIV_W = 16,
  parameter int CNT_W = 21,
  parameter int PIX_W = 11,
  parameter int NPIX  = 1024
) (
  input  logic             FPGA_CLK,
  input  logic             FPGA_RST,
  input  logic             EN,
  input  logic [DIV_W-1:0] DIV,
  input  logic [CNT_W-1:0] ST_PERIOD,
  input  logic [CNT_W-1:0] ST_HIGH,
  input  logic             EOC,
  input  logic             EOS,
  output logic             SENSOR_CLK,
  output logic             ST,
  output logic             BUSY,
  output logic             PIX_STB,
  output logic [PIX_W-1:0] PIX_IDX,
  output logic             LINE_DONE,
  output logic [PIX_W-1:0] LINE_LEN,
  output logic             OVF,
  output logic             LEN_ERR
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2} state_t;

  localparam logic [PIX_W-1:0] LP_PIX_MAX = '1;

  state_t           r_state;
  state_t           w_next_state;
  logic [1:0]       r_rst_sync;
  logic             w_rst_ready;
  logic             w_busy;
  logic             w_start;
  logic             w_stop;

  logic [DIV_W-1:0] r_div;
  logic [CNT_W-1:0] r_per;
  logic [CNT_W-1:0] r_thr;
  logic [CNT_W-1:0] w_per_eff;
  logic [CNT_W-1:0] w_high_eff;
  logic [CNT_W-1:0] w_thr_eff;

  logic [DIV_W-1:0] r_div_cnt;
  logic             r_sclk;
  logic [CNT_W-1:0] r_st_cnt;
  logic             r_st;
  logic             w_div_wrap;
  logic             w_sclk_rise;
  logic             w_st_wrap;
  logic [CNT_W-1:0] w_st_cnt_next;

  logic             r_eoc_s1, r_eoc_s2, r_eoc_d;
  logic             r_eos_s1, r_eos_s2, r_eos_d;
  logic             w_eoc_evt;
  logic             w_eos_evt;
  logic [PIX_W-1:0] r_pix_cnt;
  logic [PIX_W-1:0] w_pix_inc;
  logic [PIX_W-1:0] w_line_len_next;
  logic             r_pix_stb;
  logic [PIX_W-1:0] r_pix_idx;
  logic             r_line_done;
  logic [PIX_W-1:0] r_line_len;
  logic             r_ovf;

  // Reset release is held off two cycles so the FSM never leaves IDLE on the
  // edge where reset deassertion may still be metastable.
  always_ff @(posedge FPGA_CLK or negedge FPGA_RST) begin
    if (!FPGA_RST) r_rst_sync <= 2'b00;
    else           r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_ready = r_rst_sync[1];

  // Effective settings: P = max(ST_PERIOD,1), H = min(ST_HIGH,P); ST is high
  // while the count is at or above P-H.
  assign w_per_eff  = (ST_PERIOD == '0) ? CNT_W'(1) : ST_PERIOD;
  assign w_high_eff = (ST_HIGH > w_per_eff) ? w_per_eff : ST_HIGH;
  assign w_thr_eff  = w_per_eff - w_high_eff;

  assign w_div_wrap    = (r_div_cnt == r_div);
  assign w_sclk_rise   = w_div_wrap & ~r_sclk;
  assign w_st_wrap     = w_sclk_rise & (r_st_cnt == (r_per - CNT_W'(1)));
  assign w_st_cnt_next = w_st_wrap ? '0 : (r_st_cnt + CNT_W'(1));

  // FSM: state register
  always_ff @(posedge FPGA_CLK or negedge FPGA_RST) begin
    if (!FPGA_RST) r_state <= S_IDLE;
    else           r_state <= w_next_state;
  end

  // FSM: next state. A re-raised EN in DRAIN wins over a same-cycle wrap.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (EN && w_rst_ready) w_next_state = S_RUN;
      S_RUN:   if (!EN) w_next_state = S_DRAIN;
      S_DRAIN: begin
        if (EN)             w_next_state = S_RUN;
        else if (w_st_wrap) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    w_busy  = (r_state != S_IDLE);
    w_start = (r_state == S_IDLE) && (w_next_state == S_RUN);
    w_stop  = (r_state == S_DRAIN) && (w_next_state == S_IDLE);
  end

  // Sensor clock and ST generation
  always_ff @(posedge FPGA_CLK or negedge FPGA_RST) begin
    if (!FPGA_RST) begin
      r_div     <= '0;
      r_per     <= CNT_W'(1);
      r_thr     <= '0;
      r_div_cnt <= '0;
      r_sclk    <= 1'b0;
      r_st_cnt  <= '0;
      r_st      <= 1'b0;
    end else if (w_start) begin
      r_div     <= DIV;
      r_per     <= w_per_eff;
      r_thr     <= w_thr_eff;
      r_div_cnt <= '0;
      r_sclk    <= 1'b0;
      r_st_cnt  <= '0;
      // Count starts at 0, so ST is already high when H covers the whole period.
      r_st      <= (w_thr_eff == '0);
    end else if (w_stop) begin
      r_div_cnt <= '0;
      r_sclk    <= 1'b0;
      r_st_cnt  <= '0;
      r_st      <= 1'b0;
    end else if (w_busy) begin
      r_div_cnt <= w_div_wrap ? '0 : (r_div_cnt + DIV_W'(1));
      if (w_div_wrap) r_sclk <= ~r_sclk;
      if (w_sclk_rise) begin
        r_st_cnt <= w_st_cnt_next;
        r_st     <= (w_st_cnt_next >= r_thr);
      end
    end
  end

  // EOC/EOS synchronisers and previous-value flops for edge detection
  always_ff @(posedge FPGA_CLK or negedge FPGA_RST) begin
    if (!FPGA_RST) begin
      {r_eoc_s1, r_eoc_s2, r_eoc_d} <= 3'b000;
      {r_eos_s1, r_eos_s2, r_eos_d} <= 3'b000;
    end else begin
      {r_eoc_s1, r_eoc_s2, r_eoc_d} <= {EOC, r_eoc_s1, r_eoc_s2};
      {r_eos_s1, r_eos_s2, r_eos_d} <= {EOS, r_eos_s1, r_eos_s2};
    end
  end

  // Edges arriving while IDLE (including the start cycle) are dropped.
  assign w_eoc_evt       = w_busy & r_eoc_s2 & ~r_eoc_d;
  assign w_eos_evt       = w_busy & r_eos_s2 & ~r_eos_d;
  assign w_pix_inc       = (r_pix_cnt == LP_PIX_MAX) ? r_pix_cnt : (r_pix_cnt + PIX_W'(1));
  assign w_line_len_next = w_eoc_evt ? w_pix_inc : r_pix_cnt;

  // Pixel counter, strobes and line capture
  always_ff @(posedge FPGA_CLK or negedge FPGA_RST) begin
    if (!FPGA_RST) begin
      r_pix_cnt   <= '0;
      r_pix_stb   <= 1'b0;
      r_pix_idx   <= '0;
      r_line_done <= 1'b0;
      r_line_len  <= '0;
      r_ovf       <= 1'b0;
    end else begin
      r_pix_stb   <= 1'b0;
      r_line_done <= 1'b0;
      if (w_start) begin
        r_pix_cnt <= '0;
        r_ovf     <= 1'b0;
      end else begin
        if (w_eoc_evt) begin
          r_pix_stb <= 1'b1;
          r_pix_idx <= r_pix_cnt;
          if (w_pix_inc == LP_PIX_MAX) r_ovf <= 1'b1;
        end
        if (w_eos_evt) begin
          r_line_done <= 1'b1;
          r_line_len  <= w_line_len_next;
          r_pix_cnt   <= '0;
        end else begin
          r_pix_cnt <= w_line_len_next;
        end
      end
    end
  end

`ifdef SENSOR_SEQ_LEN_CHECK_EN
  logic r_len_err;
  always_ff @(posedge FPGA_CLK or negedge FPGA_RST) begin
    if (!FPGA_RST) r_len_err <= 1'b0;
    else           r_len_err <= w_eos_evt && (32'(w_line_len_next) != 32'(NPIX));
  end
  assign LEN_ERR = r_len_err;
`else
  assign LEN_ERR = 1'b0;
`endif

  assign SENSOR_CLK = r_sclk;
  assign ST         = r_st;
  assign BUSY       = w_busy;
  assign PIX_STB    = r_pix_stb;
  assign PIX_IDX    = r_pix_idx;
  assign LINE_DONE  = r_line_done;
  assign LINE_LEN   = r_line_len;
  assign OVF        = r_ovf;

endmodule

// File: tb/tb_sensor_seq.sv
// tb/tb_sensor_seq.sv - self-checking bench for sensor_seq
`timescale 1ns/1ps
module tb_sensor_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        en, eoc, eos;
  logic        en_b, eoc_b, eos_b;
  logic [15:0] div;
  logic [20:0] per, high;

  logic        sclk, st, busy, pix_stb, line_done, ovf, len_err;
  logic [10:0] pix_idx, line_len;
  logic        sclk_b, st_b, busy_b, pix_stb_b, line_done_b, ovf_b, len_err_b;
  logic [3:0]  pix_idx_b, line_len_b;

  int n_tests = 0;
  int n_fail  = 0;
  int qa[$];
  int ql[$];
  int qe[$];
  int qb[$];
  int exp_a, exp_l, exp_e, exp_b;

  sensor_seq dut (
    .FPGA_CLK(clk), .FPGA_RST(rst_n), .EN(en), .DIV(div), .ST_PERIOD(per), .ST_HIGH(high),
    .EOC(eoc), .EOS(eos), .SENSOR_CLK(sclk), .ST(st), .BUSY(busy), .PIX_STB(pix_stb),
    .PIX_IDX(pix_idx), .LINE_DONE(line_done), .LINE_LEN(line_len), .OVF(ovf), .LEN_ERR(len_err)
  );

  sensor_seq #(.PIX_W(4), .NPIX(15)) dut_b (
    .FPGA_CLK(clk), .FPGA_RST(rst_n), .EN(en_b), .DIV(div), .ST_PERIOD(per), .ST_HIGH(high),
    .EOC(eoc_b), .EOS(eos_b), .SENSOR_CLK(sclk_b), .ST(st_b), .BUSY(busy_b), .PIX_STB(pix_stb_b),
    .PIX_IDX(pix_idx_b), .LINE_DONE(line_done_b), .LINE_LEN(line_len_b), .OVF(ovf_b), .LEN_ERR(len_err_b)
  );

  function automatic int exp_err(int len);
`ifdef SENSOR_SEQ_LEN_CHECK_EN
    return (len != 1024) ? 1 : 0;
`else
    return 0;
`endif
  endfunction

  // Scoreboard for the full-width DUT: pops on every strobe
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (pix_stb === 1'b1) begin
        n_tests++;
        if (qa.size() == 0) begin
          n_fail++; $display("FAIL pix_extra idx=%0d required no strobe", pix_idx);
        end else begin
          exp_a = qa.pop_front();
          if (pix_idx !== 11'(exp_a)) begin
            n_fail++; $display("FAIL pix_idx got %0d required %0d", pix_idx, exp_a);
          end
        end
      end
      if (line_done === 1'b1) begin
        n_tests++;
        if (ql.size() == 0) begin
          n_fail++; $display("FAIL line_extra len=%0d required no line_done", line_len);
        end else begin
          exp_l = ql.pop_front();
          exp_e = qe.pop_front();
          if (line_len !== 11'(exp_l) || len_err !== 1'(exp_e)) begin
            n_fail++; $display("FAIL line_len got %0d/%0b required %0d/%0d", line_len, len_err, exp_l, exp_e);
          end
        end
      end
      if (len_err === 1'b1 && line_done !== 1'b1) begin
        n_tests++; n_fail++; $display("FAIL len_err_stray got 1 required 0");
      end
    end
  end

  // Scoreboard for the 4-bit DUT
  always @(negedge clk) begin
    if (rst_n === 1'b1 && pix_stb_b === 1'b1) begin
      n_tests++;
      if (qb.size() == 0) begin
        n_fail++; $display("FAIL pixb_extra idx=%0d required no strobe", pix_idx_b);
      end else begin
        exp_b = qb.pop_front();
        if (pix_idx_b !== 4'(exp_b)) begin
          n_fail++; $display("FAIL pixb_idx got %0d required %0d", pix_idx_b, exp_b);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_eoc();
    eoc = 1'b1; cyc(2); eoc = 1'b0; cyc(2);
  endtask

  task automatic start_run(input int d, input int p, input int h);
    div = 16'(d); per = 21'(p); high = 21'(h); en = 1'b1;
    cyc(1);
  endtask

  task automatic stop_run();
    int t;
    en = 1'b0; t = 0;
    while (busy === 1'b1 && t < 3000) begin @(negedge clk); t++; end
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL stop_timeout busy=%0b required 0", busy); end
  endtask

  task automatic test_reset();
    logic [31:0] got;
    rst_n = 1'b0; en = 1'b0; eoc = 1'b0; eos = 1'b0;
    en_b = 1'b0; eoc_b = 1'b0; eos_b = 1'b0;
    div = 16'd0; per = 21'd1; high = 21'd0;
    cyc(3);
    got = {sclk, st, busy, pix_stb, line_done, ovf, len_err, pix_idx, line_len};
    for (int i = 0; i < 7; i++) begin
      n_tests++;
      if (got[22 + i] !== 1'b0) begin n_fail++; $display("FAIL reset_bit%0d got %0b required 0", i, got[22 + i]); end
    end
    n_tests++;
    if (pix_idx !== 11'd0 || line_len !== 11'd0) begin
      n_fail++; $display("FAIL reset_fields got %0d/%0d required 0/0", pix_idx, line_len);
    end
    rst_n = 1'b1; en = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      n_tests++;
      if (busy !== ((k == 3) ? 1'b1 : 1'b0)) begin
        n_fail++; $display("FAIL reset_release_k%0d busy=%0b required %0b", k, busy, (k == 3));
      end
    end
    stop_run();
  endtask

  // DIV=3, P=10, H=2; EN dropped after rise 21, so the wrap at rise 30 (k=236) ends the run.
  task automatic test_clock_st();
    int r;
    logic e_sclk, e_st, e_busy;
    div = 16'd3; per = 21'd10; high = 21'd2; en = 1'b1;
    for (int k = 0; k <= 250; k++) begin
      @(negedge clk);
      r = (k >= 4) ? ((k - 4) / 8 + 1) : 0;
      if (k >= 236) begin
        e_sclk = 1'b0; e_st = 1'b0; e_busy = 1'b0;
      end else begin
        e_sclk = ((k / 4) % 2) == 1;
        e_st   = (r % 10) >= 8;
        e_busy = 1'b1;
      end
      n_tests++;
      if (sclk !== e_sclk || st !== e_st || busy !== e_busy) begin
        n_fail++;
        $display("FAIL clock_st_k%0d got sclk=%0b st=%0b busy=%0b required %0b %0b %0b", k, sclk, st, busy, e_sclk, e_st, e_busy);
      end
      if (k == 170) en = 1'b0;
    end
  endtask

  task automatic test_drain_rearm();
    int r;
    logic e_sclk, e_st;
    div = 16'd0; per = 21'd4; high = 21'd1; en = 1'b1;
    for (int k = 0; k <= 40; k++) begin
      @(negedge clk);
      r = (k + 1) / 2;
      e_sclk = (k % 2) == 1;
      e_st   = (r % 4) >= 3;
      n_tests++;
      if (sclk !== e_sclk || st !== e_st || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL rearm_k%0d got sclk=%0b st=%0b busy=%0b required %0b %0b 1", k, sclk, st, busy, e_sclk, e_st);
      end
      if (k == 2) en = 1'b0;
      if (k == 4) en = 1'b1;
    end
    stop_run();
  endtask

  task automatic test_st_edges();
    for (int h = 0; h <= 4; h += 4) begin
      div = 16'd0; per = 21'd4; high = 21'(h); en = 1'b1;
      for (int k = 0; k < 30; k++) begin
        @(negedge clk);
        n_tests++;
        if (st !== (h == 4) || busy !== 1'b1) begin
          n_fail++; $display("FAIL st_edge_h%0d_k%0d got st=%0b busy=%0b required %0b 1", h, k, st, busy, (h == 4));
        end
      end
      stop_run();
    end
  endtask

  task automatic check_drained(input string name);
    cyc(4);
    n_tests++;
    if (qa.size() != 0 || ql.size() != 0) begin
      n_fail++; $display("FAIL %s_pending pix=%0d line=%0d required 0 0", name, qa.size(), ql.size());
    end
  endtask

  task automatic test_line(input int n);
    start_run(0, 4, 1);
    for (int i = 0; i < n; i++) begin qa.push_back(i); pulse_eoc(); end
    ql.push_back(n); qe.push_back(exp_err(n));
    eos = 1'b1; cyc(2); eos = 1'b0; cyc(2);
    check_drained("line");
    stop_run();
  endtask

  task automatic test_eoc_eos_same();
    start_run(0, 4, 1);
    for (int i = 0; i < 5; i++) begin qa.push_back(i); pulse_eoc(); end
    qa.push_back(5); ql.push_back(6); qe.push_back(exp_err(6));
    eoc = 1'b1; eos = 1'b1; cyc(2); eoc = 1'b0; eos = 1'b0; cyc(2);
    qa.push_back(0); pulse_eoc();
    check_drained("same_cycle");
    stop_run();
  endtask

  task automatic test_overflow();
    int t;
    div = 16'd0; per = 21'd4; high = 21'd1; en_b = 1'b1; cyc(1);
    for (int i = 1; i <= 20; i++) begin
      qb.push_back((i - 1 > 15) ? 15 : i - 1);
      eoc_b = 1'b1; cyc(2); eoc_b = 1'b0; cyc(2);
      n_tests++;
      if (ovf_b !== (i >= 15)) begin n_fail++; $display("FAIL ovf_after_%0d got %0b required %0b", i, ovf_b, (i >= 15)); end
    end
    eos_b = 1'b1; cyc(2); eos_b = 1'b0; cyc(4);
    n_tests++;
    if (line_len_b !== 4'd15 || ovf_b !== 1'b1 || qb.size() != 0) begin
      n_fail++; $display("FAIL ovf_line got len=%0d ovf=%0b pend=%0d required 15 1 0", line_len_b, ovf_b, qb.size());
    end
    en_b = 1'b0; t = 0;
    while (busy_b === 1'b1 && t < 3000) begin @(negedge clk); t++; end
    en_b = 1'b1; cyc(1);
    n_tests++;
    if (busy_b !== 1'b1 || ovf_b !== 1'b0) begin
      n_fail++; $display("FAIL ovf_restart got busy=%0b ovf=%0b required 1 0", busy_b, ovf_b);
    end
    en_b = 1'b0; t = 0;
    while (busy_b === 1'b1 && t < 3000) begin @(negedge clk); t++; end
    n_tests++;
    if (busy_b !== 1'b0) begin n_fail++; $display("FAIL ovf_stop busy=%0b required 0", busy_b); end
  endtask

  task automatic test_reset_mid();
    start_run(1, 10, 3);
    for (int i = 0; i < 3; i++) begin qa.push_back(i); pulse_eoc(); end
    cyc(3);
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({sclk, st, busy, pix_stb, line_done, ovf, len_err} !== 7'd0 || pix_idx !== 11'd0 || line_len !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_mid got sclk=%0b st=%0b busy=%0b stb=%0b ld=%0b ovf=%0b le=%0b idx=%0d len=%0d required all 0",
               sclk, st, busy, pix_stb, line_done, ovf, len_err, pix_idx, line_len);
    end
    en = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(3);
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_clock_st();
    test_drain_rearm();
    test_st_edges();
    test_line(1024);
    test_line(1000);
    test_eoc_eos_same();
    test_overflow();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sensor_seq.md
# sensor_seq

Parametrised line-sensor readout sequencer for the S10077 board. It generates the sensor clock and ST start pulse from FPGA_CLK, with run-time programmable divider, period and high time, and a clean start/stop handshake. It synchronises EOC/EOS from the sensor and produces per-pixel strobes and indices, per-line length capture and overflow flags. It replaces the fixed divider / ST generator / EOC counter chain at the top level. It is fully single-clock: SENSOR_CLK is a registered output, never used as a clock internally.

## Interface
- DIV_W, 16, width of the divider setting
- CNT_W, 21, width of the ST period/high settings and ST counter
- PIX_W, 11, width of pixel index/count
- NPIX, 1024, expected pixels per line (length check only)

- FPGA_CLK  in  1  system clock; all logic on rising edge
- FPGA_RST  in  1  asynchronous, active-low reset
- EN  in  1  run request; level-sensitive
- DIV  in  DIV_W  SENSOR_CLK half-period minus 1, in FPGA_CLK cycles
- ST_PERIOD  in  CNT_W  ST period in SENSOR_CLK cycles
- ST_HIGH  in  CNT_W  ST high time in SENSOR_CLK cycles
- EOC  in  1  sensor end-of-conversion, asynchronous
- EOS  in  1  sensor end-of-scan, asynchronous
- SENSOR_CLK  out  1  sensor drive clock, registered
- ST  out  1  sensor start pulse, registered
- BUSY  out  1  state != IDLE
- PIX_STB  out  1  one-cycle strobe per EOC rising edge
- PIX_IDX  out  PIX_W  index of the pixel strobed, valid with PIX_STB
- LINE_DONE  out  1  one-cycle strobe per EOS rising edge
- LINE_LEN  out  PIX_W  pixel count of last completed line, held
- OVF  out  1  sticky; pixel counter saturated
- LEN_ERR  out  1  one-cycle; completed line length != NPIX

## Operation
- States: IDLE, RUN, DRAIN.
  - IDLE → RUN when EN=1. On this transition, shadow DIV/ST_PERIOD/ST_HIGH, clear divider, ST counter, pixel counter and OVF.
  - RUN → DRAIN when EN=0.
  - DRAIN → RUN if EN returns to 1 before the ST counter wraps. No reshadow in this case.
  - DRAIN → IDLE on ST counter wrap (period end).
- Inputs are ignored outside IDLE; changes mid-run take effect at the next IDLE→RUN.
- Divider:
  - Counts 0..DIV; at DIV it wraps and toggles SENSOR_CLK.
  - DIV=0 gives SENSOR_CLK = FPGA_CLK/2.
  - SENSOR_CLK is forced 0 in IDLE.
- ST counter:
  - Advances only in the cycle SENSOR_CLK rises.
  - Wraps 0..P-1, where P = max(ST_PERIOD,1).
  - ST = 1 when count >= P − H, where H = min(ST_HIGH,P). ST is high for the last H sensor clocks of each period.
  - H=0: ST never high. H>=P: ST permanently high in RUN.
  - ST is forced 0 in IDLE.
- EOC/EOS:
  - Each passes through a 2-flop synchroniser, then rising-edge detect.
  - Edges are processed in RUN and DRAIN; discarded in IDLE.
- Pixel counter:
  - On an EOC edge: PIX_STB=1, PIX_IDX = count, count++.
  - The counter saturates at 2^PIX_W−1 and sets OVF at saturation. A further strobe still fires, with PIX_IDX at the saturated value.
- EOS edge:
  - LINE_DONE=1, LINE_LEN = count (including an EOC edge in the same cycle), count = 0.
  - OVF is not cleared by EOS.

## Timing
- Reset values: SENSOR_CLK=0, ST=0, BUSY=0, PIX_STB=0, PIX_IDX=0, LINE_DONE=0, LINE_LEN=0, OVF=0, LEN_ERR=0, state IDLE.
- BUSY=1 the cycle after EN is sampled high in IDLE.
- SENSOR_CLK first rises DIV+1 cycles after entering RUN. It stays high DIV+1 cycles and low DIV+1 cycles.
- ST changes on the same FPGA_CLK edge as the SENSOR_CLK rise that moves the counter across the threshold.
- PIX_STB and LINE_DONE are asserted 3 FPGA_CLK edges after the EOC/EOS input rises (sync 2 + edge 1).
- Minimum EOC/EOS high and low times: 2 FPGA_CLK cycles.
- Entering IDLE from DRAIN: SENSOR_CLK and ST go 0 on the same edge, and BUSY drops on that edge.
- Asserting FPGA_RST mid-operation clears all state immediately. Release is synchronous-safe: the first active edge is after 2 deasserted cycles.

## Configuration
- SENSOR_SEQ_LEN_CHECK_EN defined: on each LINE_DONE, LEN_ERR pulses in the same cycle if LINE_LEN_next != NPIX.
- SENSOR_SEQ_LEN_CHECK_EN undefined: LEN_ERR is tied 0 and no comparator is built.

## Test plan
- Reset, EN=1, DIV=3, ST_PERIOD=10, ST_HIGH=2 → SENSOR_CLK period 8 cycles, first rise 4 cycles after RUN entry; ST high during sensor clocks 8–9 of each 10-clock period.
- RUN with 1024 EOC pulses then EOS → PIX_IDX 0..1023 in order, LINE_DONE once, LINE_LEN=1024, LEN_ERR=0. With 1000 pulses, LEN_ERR=1 (macro defined) or 0 (undefined).
- EOC and EOS rising in the same cycle after 5 prior EOC pulses → PIX_STB with PIX_IDX=5, LINE_LEN=6, next line starts at index 0.
- PIX_W=4, 20 EOC pulses without EOS → OVF=1 after the 15th, PIX_IDX stuck at 15, OVF stays set across EOS; the next IDLE→RUN clears it.
- EN dropped mid-period → DRAIN continues to period end, then IDLE with SENSOR_CLK=0, ST=0, BUSY=0. Re-raising EN during DRAIN keeps running without a glitch.
- FPGA_RST asserted mid-line, edge cases ST_HIGH=0 and ST_HIGH=ST_PERIOD → all outputs return to reset values immediately; ST never high, or ST constantly high in RUN, respectively.
